// File: rtl/fround_arb_if.sv
// Request/response bundle around the shared fround datapath.
// RspIllegal exists only when FROUND_ARB_FRMCHK_EN is defined.
interface fround_arb_if #(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int FMTBITS = 2,
    parameter int LOGFLEN = 6,
    parameter int TAGW    = 5
);
    logic [1:0]                ReqValid;
    logic [1:0]                ReqReady;
    logic [1:0][NE+NF+1:0]     ReqX;
    logic [1:0]                ReqNaN;
    logic [1:0]                ReqSNaN;
    logic [1:0][FMTBITS-1:0]   ReqFmt;
    logic [1:0][2:0]           ReqFrm;
    logic [1:0][LOGFLEN-1:0]   ReqNf;
    logic [1:0]                ReqNX;
    logic [1:0][TAGW-1:0]      ReqTag;
    logic                      Flush;
    logic                      RspValid;
    logic                      RspReady;
    logic [FLEN-1:0]           RspRes;
    logic                      RspNV;
    logic                      RspNX;
    logic                      RspSrc;
    logic [TAGW-1:0]           RspTag;
`ifdef FROUND_ARB_FRMCHK_EN
    logic                      RspIllegal;
`endif

    modport master (
        output ReqValid, ReqX, ReqNaN, ReqSNaN, ReqFmt, ReqFrm, ReqNf, ReqNX, ReqTag,
        output Flush, RspReady,
        input  ReqReady, RspValid, RspRes, RspNV, RspNX, RspSrc, RspTag
`ifdef FROUND_ARB_FRMCHK_EN
        , input RspIllegal
`endif
    );

    modport slave (
        input  ReqValid, ReqX, ReqNaN, ReqSNaN, ReqFmt, ReqFrm, ReqNf, ReqNX, ReqTag,
        input  Flush, RspReady,
        output ReqReady, RspValid, RspRes, RspNV, RspNX, RspSrc, RspTag
`ifdef FROUND_ARB_FRMCHK_EN
        , output RspIllegal
`endif
    );
endinterface

// File: rtl/fround_arb.sv
// Round-robin arbiter sharing one combinational fround datapath between two requesters.
// Optional FROUND_ARB_FRMCHK_EN: illegal Frm (101..111) is answered directly with NV and RspIllegal.
module fround_arb #(
    parameter int FLEN    = 64,
    parameter int NE      = 11,
    parameter int NF      = 52,
    parameter int FMTBITS = 2,
    parameter int LOGFLEN = 6,
    parameter int TAGW    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    fround_arb_if.slave        bus,
    output logic               DpXs,
    output logic [NE-1:0]      DpXe,
    output logic [NF:0]        DpXm,
    output logic               DpNaN,
    output logic               DpSNaN,
    output logic [FMTBITS-1:0] DpFmt,
    output logic [2:0]         DpFrm,
    output logic [LOGFLEN-1:0] DpNf,
    output logic               DpNX,
    input  logic [FLEN-1:0]    DpRes,
    input  logic               DpNV,
    input  logic               DpNXf,
    output logic               Busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, HOLD = 2'd2} state_t;

    state_t          state, next_state;
    logic            ptr;
    logic            acc, grant, win, illegal;
    logic            src_q;
    logic [TAGW-1:0] tag_q;
    logic [FLEN-1:0] rsp_res;
    logic            rsp_nv, rsp_nx, rsp_src;
    logic [TAGW-1:0] rsp_tag;
`ifdef FROUND_ARB_FRMCHK_EN
    logic            rsp_illegal;
`endif

    // Reset gates the grant so ReqReady drops the moment reset_n falls.
    always_comb begin
        acc = ~bus.Flush & reset_n & ((state == IDLE) | ((state == HOLD) & bus.RspReady));
        case (bus.ReqValid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ptr;
            default: win = 1'b0;
        endcase
        grant = acc & (|bus.ReqValid);
        bus.ReqReady = 2'b00;
        if (grant) bus.ReqReady[win] = 1'b1;
`ifdef FROUND_ARB_FRMCHK_EN
        illegal = grant & (bus.ReqFrm[win] > 3'b100);
`else
        illegal = 1'b0;
`endif
        next_state = state;
        if (bus.Flush)                                next_state = IDLE;
        else if (grant)                               next_state = illegal ? HOLD : EVAL;
        else if (state == EVAL)                       next_state = HOLD;
        else if ((state == HOLD) && bus.RspReady)     next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= next_state;
            if (grant && (bus.ReqValid == 2'b11)) ptr <= ~win;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DpXs   <= '0;
            DpXe   <= '0;
            DpXm   <= '0;
            DpNaN  <= '0;
            DpSNaN <= '0;
            DpFmt  <= '0;
            DpFrm  <= '0;
            DpNf   <= '0;
            DpNX   <= '0;
            src_q  <= '0;
            tag_q  <= '0;
        end else if (grant) begin
            DpXs   <= bus.ReqX[win][NE+NF+1];
            DpXe   <= bus.ReqX[win][NE+NF:NF+1];
            DpXm   <= bus.ReqX[win][NF:0];
            DpNaN  <= bus.ReqNaN[win];
            DpSNaN <= bus.ReqSNaN[win];
            DpFmt  <= bus.ReqFmt[win];
            DpFrm  <= bus.ReqFrm[win];
            DpNf   <= bus.ReqNf[win];
            DpNX   <= bus.ReqNX[win];
            src_q  <= win;
            tag_q  <= bus.ReqTag[win];
        end
    end

    // Results are sampled only at the end of an unflushed EVAL and then held through HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_res     <= '0;
            rsp_nv      <= 1'b0;
            rsp_nx      <= 1'b0;
            rsp_src     <= 1'b0;
            rsp_tag     <= '0;
`ifdef FROUND_ARB_FRMCHK_EN
            rsp_illegal <= 1'b0;
`endif
        end else if ((state == EVAL) && !bus.Flush) begin
            rsp_res     <= DpRes;
            rsp_nv      <= DpNV;
            rsp_nx      <= DpNXf;
            rsp_src     <= src_q;
            rsp_tag     <= tag_q;
`ifdef FROUND_ARB_FRMCHK_EN
            rsp_illegal <= 1'b0;
        end else if (illegal) begin
            rsp_res     <= '0;
            rsp_nv      <= 1'b1;
            rsp_nx      <= 1'b0;
            rsp_src     <= win;
            rsp_tag     <= bus.ReqTag[win];
            rsp_illegal <= 1'b1;
`endif
        end
    end

    assign bus.RspValid   = (state == HOLD);
    assign bus.RspRes     = rsp_res;
    assign bus.RspNV      = rsp_nv;
    assign bus.RspNX      = rsp_nx;
    assign bus.RspSrc     = rsp_src;
    assign bus.RspTag     = rsp_tag;
`ifdef FROUND_ARB_FRMCHK_EN
    assign bus.RspIllegal = rsp_illegal;
`endif
    assign Busy           = (state != IDLE);
endmodule

// File: doc/fround_arb.md
Name: fround_arb

Overview:
- Shares one combinational `fround` round-to-integer datapath (Zfa `fround`/`froundnx`) between two requesters.
  - Requester 0: scalar FPU issue.
  - Requester 1: secondary requester, e.g. the vector/FCVT sequencer.
- Round-robin arbitration between the two.
- Registers the winner's operands into the datapath, captures the result and flags one cycle later, and holds them until the consumer accepts.
- Sits between FPU issue and the FPU result mux.

Parameters:
- FLEN, 64, widest FP format width.
- NE, 11, exponent width of the widest format.
- NF, 52, fraction width of the widest format.
- FMTBITS, 2, format select width.
- LOGFLEN, 6, width of Nf.
- TAGW, 5, opaque destination tag width carried with each request.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- ReqValid  in  2  per-requester request valid.
- ReqReady  out  2  per-requester grant/accept.
- ReqX  in  2x(1+NE+NF+1)  {Xs, Xe, Xm} per requester; Xm is U1.NF.
- ReqNaN  in  2  X is NaN.
- ReqSNaN  in  2  X is signalling NaN.
- ReqFmt  in  2xFMTBITS  format.
- ReqFrm  in  2x3  rounding mode.
- ReqNf  in  2xLOGFLEN  fractional bits of the format.
- ReqNX  in  2  froundnx (inexact may be raised).
- ReqTag  in  2xTAGW  tag.
- Flush  in  1  kill in-flight operation.
- DpXs, DpXe, DpXm, DpNaN, DpSNaN, DpFmt, DpFrm, DpNf, DpNX  out  matching widths  registered operands to the datapath.
- DpRes  in  FLEN  datapath result.
- DpNV  in  1  datapath invalid flag.
- DpNXf  in  1  datapath inexact flag.
- RspValid  out  1  result valid.
- RspReady  in  1  consumer accepts.
- RspRes  out  FLEN  result.
- RspNV  out  1  invalid flag.
- RspNX  out  1  inexact flag.
- RspSrc  out  1  winning requester.
- RspTag  out  TAGW  tag.
- Busy  out  1  state != IDLE.

Behaviour:
- **Reset** (async assert, sync deassert):
  - state=IDLE, priority pointer=0.
  - All Dp* operand registers 0.
  - RspValid=0; RspRes, RspNV, RspNX, RspSrc, RspTag all 0.
  - Busy=0.
- **States:** IDLE, EVAL, HOLD.
- **Accept condition:** `acc = (state==IDLE) | (state==HOLD & RspReady)`, qualified by ~Flush.
- **Arbitration:** ReqReady[i]=1 only for the winner, and only when acc holds.
  - One requester valid: it wins.
  - Both valid: the requester equal to the pointer wins; the pointer then flips to the other requester.
  - Pointer updates only on a grant.
  - ReqReady is combinational from ReqValid and state.
  - Requesters must hold all Req* fields stable until granted.
- **On grant:**
  - Winner's fields are registered into Dp* and the internal src/tag registers.
  - State moves to EVAL.
  - Accepting in HOLD in the same cycle as the RspReady handshake is legal (back-to-back).
- **EVAL:** DpRes, DpNV, DpNXf are combinational from Dp*. They are captured into Rsp* at the end of EVAL; state moves to HOLD.
- **HOLD:**
  - RspValid=1; Rsp* stay stable until RspReady.
  - RspReady without a new grant: state moves to IDLE.
  - RspReady with a new grant: state moves to EVAL.
- **Latency and throughput:** grant in cycle n, RspValid in cycle n+2. Throughput is 1 result per 2 cycles.
- **Flush:** in any state, next state is IDLE and RspValid drops next cycle. No grant is given in the flush cycle, and the pointer is unchanged. Dp* keep their values (don't-care).
- **Simultaneous events:**
  - Flush and RspReady in HOLD: Flush wins; the consumer treats the result as discarded.
  - Flush during EVAL: no result is ever presented.
- The datapath treats Frm outside 000..100 as RoundUp=0. The arbiter forwards Frm unchanged unless the optional feature is compiled in.

Optional Feature:
- Macro: FROUND_ARB_FRMCHK_EN.
- **Defined:**
  - Grant logic checks the winner's Frm. If Frm is 101, 110 or 111, the request is accepted but EVAL is skipped: state goes IDLE/HOLD → HOLD directly.
  - Response is RspRes={FLEN{0}}, RspNV=1, RspNX=0, with src and tag preserved.
  - Extra output port RspIllegal (1 bit, reset 0) is asserted with that response.
- **Undefined:** no check, no RspIllegal port; every request goes through EVAL.

Test Plan:
- **Single request, double 2.5, RNE, froundnx:** Req0 with Xs=0, Xe=0x400, Xm=1.01b (rest 0), Frm=000, ReqNX=1, tag=3 → RspValid at grant+2; RspRes=0x4000000000000000, RspNX=1, RspNV=0, RspSrc=0, RspTag=3.
- **Contention:** both requesters valid continuously with RspReady=1 → grants alternate 0,1,0,1 starting from pointer 0, one grant every 2 cycles; responses return in grant order with correct tags.
- **Back-pressure:** RspReady=0 for 5 cycles in HOLD → RspRes, RspTag and RspValid stable; no ReqReady asserted; on RspReady=1, the waiting requester is granted that same cycle.
- **Signalling NaN:** ReqSNaN=1, ReqNaN=1, Fmt=01 → RspRes=0x7FF8000000000000, RspNV=1, RspNX=0.
- **Flush:** Flush asserted in EVAL → RspValid never rises, Busy=0 next cycle, pointer unchanged; next request completes normally.
- **Reset mid-operation:** reset_n low in HOLD → RspValid=0 and ReqReady=0 immediately (asynchronous); pointer=0 after release. With FROUND_ARB_FRMCHK_EN, Frm=101 → RspIllegal=1, RspNV=1 at grant+1.
